// File: rtl/vram_pkg.sv
// Shared definitions for the 160x100 RGB332 video memory and its arbiter.
package vram_pkg;

  localparam int VRAM_W      = 160;
  localparam int VRAM_H      = 100;
  localparam int VRAM_DEPTH  = VRAM_W * VRAM_H;
  localparam int VRAM_ADDR_W = 14;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VID,
    GNT_CLR,
    GNT_CPU
  } grant_t;

  typedef enum logic {
    CLR_IDLE,
    CLR_FILL
  } clr_state_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO buffering CPU writes (address and data packed together).
module vram_wr_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = store[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM scheduler: video reads beat the fill engine, which beats buffered CPU writes.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DEPTH      = VRAM_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [7:0]        vid_data,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ready,
  input  logic              clear_start,
  input  logic [7:0]        clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int                ENTRY_W   = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  grant_t                         grant;
  clr_state_t                     clr_state;
  logic [ADDR_W-1:0]              clr_ptr;
  logic [7:0]                     clr_color;
  logic                           vid_hit;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [ENTRY_W-1:0]             fifo_head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_unused;
  logic [ADDR_W-1:0]              head_addr;
  logic [7:0]                     head_data;
  logic                           rd_pend;
  logic                           rd_hit;

  assign vid_hit   = vid_req && (vid_addr <= LAST_ADDR);
  assign cpu_ready = !fifo_full;
  assign fifo_push = cpu_wr && cpu_ready;
  assign fifo_pop  = (grant == GNT_CPU);
  assign head_addr = fifo_head[ENTRY_W-1:8];
  assign head_data = fifo_head[7:0];

  vram_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .pclk      (pclk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({cpu_addr, cpu_din}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level_unused)
  );

  // Out-of-range video reads leave the slot free for the lower-priority requesters.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (vid_hit)                     grant = GNT_VID;
      else if (clr_state == CLR_FILL)  grant = GNT_CLR;
      else if (!fifo_empty)            grant = GNT_CPU;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (grant)
      GNT_VID: mem_addr = vid_addr;
      GNT_CLR: begin
        mem_addr  = clr_ptr;
        mem_we    = 1'b1;
        mem_wdata = clr_color;
      end
      GNT_CPU: begin
        if (head_addr <= LAST_ADDR) begin
          mem_addr  = head_addr;
          mem_we    = 1'b1;
          mem_wdata = head_data;
        end
      end
      default: ;
    endcase
  end

  // Fixed two-stage read pipeline; a miss still produces a valid beat carrying zero.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      rd_pend   <= 1'b0;
      rd_hit    <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= 8'h00;
    end else begin
      rd_pend   <= vid_req;
      rd_hit    <= vid_hit;
      vid_valid <= rd_pend;
      vid_data  <= rd_hit ? mem_rdata : 8'h00;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      clr_state  <= CLR_IDLE;
      clr_ptr    <= '0;
      clr_color  <= 8'h00;
      clear_busy <= 1'b0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          if (clear_start) begin
            clr_state  <= CLR_FILL;
            clr_ptr    <= '0;
            clr_color  <= clear_color;
            clear_busy <= 1'b1;
          end
        end
        CLR_FILL: begin
          if (grant == GNT_CLR) begin
            if (clr_ptr == LAST_ADDR) begin
              clr_state  <= CLR_IDLE;
              clear_busy <= 1'b0;
            end else begin
              clr_ptr <= clr_ptr + ADDR_W'(1);
            end
          end
        end
        default: clr_state <= CLR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural synchronous RAM on the memory port.
module tb_vram_arbiter;

  localparam int DEPTH = 16000;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_exp_t;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  logic        pclk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic        cpu_wr;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_ready;
  logic        clear_start;
  logic [7:0]  clear_color;
  logic        clear_busy;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram     [0:16383];
  logic [7:0]  exp_mem [0:16383];
  rd_exp_t     vq[$];
  wr_exp_t     wq[$];
  rd_exp_t     rdE;
  wr_exp_t     wrE;
  logic        expValid;

  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int fillPtr    = 0;
  int fillWrites = 0;
  int fillBad    = 0;
  logic [7:0] fillColor = 8'h00;

  vram_arbiter dut (
    .pclk        (pclk),
    .reset       (reset),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_valid   (vid_valid),
    .vid_data    (vid_data),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_ready   (cpu_ready),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(posedge pclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Read results must show up exactly two cycles after the request, never otherwise.
  always @(negedge pclk) begin
    if (!reset) begin
      expValid = (vq.size() > 0) && (vq[0].due == cyc);
      if (vid_valid || expValid) begin
        checkOutput("vid_valid", vid_valid, expValid);
        if (expValid) begin
          rdE = vq.pop_front();
          if (vid_valid) checkOutput("vid_data", vid_data, rdE.data);
        end
      end
    end
  end

  // Fill writes are tallied against the bench pointer; every other write must match the CPU queue.
  always @(negedge pclk) begin
    if (!reset && mem_we) begin
      if (clear_busy) begin
        if (mem_addr != 14'(fillPtr) || mem_wdata != fillColor) fillBad++;
        if (fillPtr < 16384) exp_mem[fillPtr] = fillColor;
        fillPtr++;
        fillWrites++;
      end else begin
        checkOutput("wr_expected", mem_we, wq.size() > 0);
        if (wq.size() > 0) begin
          wrE = wq.pop_front();
          checkOutput("wr_addr", mem_addr, wrE.addr);
          checkOutput("wr_data", mem_wdata, wrE.data);
          exp_mem[wrE.addr] = wrE.data;
        end
      end
    end
    if (reset || !clear_busy) fillPtr = 0;
  end

  task automatic applyStimulus(input logic vreq, input logic [13:0] vaddr,
                               input logic cwr, input logic [13:0] caddr, input logic [7:0] cdin,
                               input logic cstart, input logic [7:0] ccolor);
    rd_exp_t r;
    wr_exp_t w;
    @(posedge pclk);
    #1;
    vid_req     = vreq;
    vid_addr    = vaddr;
    cpu_wr      = cwr;
    cpu_addr    = caddr;
    cpu_din     = cdin;
    clear_start = cstart;
    clear_color = ccolor;
    if (vreq) begin
      r.data = (int'(vaddr) < DEPTH) ? exp_mem[vaddr] : 8'h00;
      r.due  = cyc + 2;
      vq.push_back(r);
    end
    if (cwr && int'(caddr) < DEPTH) begin
      w.addr = caddr;
      w.data = cdin;
      wq.push_back(w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 14'd0, 1'b0, 14'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic waitFillDone(output int busyCnt);
    busyCnt = 0;
    for (int i = 0; i < 20000; i++) begin
      idle(1);
      @(negedge pclk);
      if (clear_busy) busyCnt++;
      else break;
    end
  endtask

  initial begin
    int          busyCnt;
    int          startWr;
    int          startBad;
    int          cut;
    logic [13:0] spots [4];

    reset       = 1'b1;
    vid_req     = 1'b0;
    vid_addr    = '0;
    cpu_wr      = 1'b0;
    cpu_addr    = '0;
    cpu_din     = '0;
    clear_start = 1'b0;
    clear_color = '0;

    repeat (3) @(posedge pclk);
    #1;
    checkOutput("rst_vid_valid", vid_valid, 0);
    checkOutput("rst_vid_data", vid_data, 0);
    checkOutput("rst_cpu_ready", cpu_ready, 1);
    checkOutput("rst_clear_busy", clear_busy, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    @(negedge pclk);
    reset = 1'b0;

    // Read latency after a CPU write.
    applyStimulus(1'b0, 14'd0, 1'b1, 14'd100, 8'hA5, 1'b0, 8'h00);
    idle(3);
    applyStimulus(1'b1, 14'd100, 1'b0, 14'd0, 8'h00, 1'b0, 8'h00);
    @(negedge pclk);
    checkOutput("lat_mem_we", mem_we, 0);
    checkOutput("lat_mem_addr", mem_addr, 100);
    idle(3);

    // Out-of-range CPU write is dropped silently.
    applyStimulus(1'b0, 14'd0, 1'b1, 14'd16000, 8'hEE, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      @(negedge pclk);
      checkOutput("oorc_mem_we", mem_we, 0);
    end

    // Video starves the FIFO until it fills; then it drains back to back.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 14'd100, i < 4, 14'(300 + i), 8'(16 + i), 1'b0, 8'h00);
      @(negedge pclk);
      checkOutput("prio_mem_we", mem_we, 0);
      checkOutput("prio_ready", cpu_ready, i < 4);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      @(negedge pclk);
      checkOutput("drain_mem_we", mem_we, 1);
    end
    idle(3);
    checkOutput("drain_left", wq.size(), 0);

    // Out-of-range video read hands its slot to a queued CPU write.
    applyStimulus(1'b1, 14'd100, 1'b1, 14'd400, 8'h44, 1'b0, 8'h00);
    applyStimulus(1'b1, 14'd16383, 1'b0, 14'd0, 8'h00, 1'b0, 8'h00);
    @(negedge pclk);
    checkOutput("oorv_mem_we", mem_we, 1);
    checkOutput("oorv_mem_addr", mem_addr, 400);
    idle(4);
    checkOutput("oorv_left", wq.size(), 0);

    // Full fill with two CPU writes queued behind it.
    fillColor = 8'h1C;
    startWr   = fillWrites;
    startBad  = fillBad;
    applyStimulus(1'b0, 14'd0, 1'b0, 14'd0, 8'h00, 1'b1, 8'h1C);
    busyCnt = 0;
    for (int i = 0; i < 20000; i++) begin
      applyStimulus(1'b0, 14'd0, i < 2, 14'd5, (i == 0) ? 8'hFF : 8'h03, 1'b0, 8'h00);
      @(negedge pclk);
      if (clear_busy) busyCnt++;
      else break;
    end
    checkOutput("fill_busy_len", busyCnt, 16000);
    idle(4);
    checkOutput("fill_count", fillWrites - startWr, 16000);
    checkOutput("fill_bad", fillBad - startBad, 0);
    checkOutput("fill_cpu_left", wq.size(), 0);
    spots[0] = 14'd0;
    spots[1] = 14'd7999;
    spots[2] = 14'd15999;
    spots[3] = 14'd5;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, spots[i], 1'b0, 14'd0, 8'h00, 1'b0, 8'h00);
    idle(4);

    // Reset in the middle of a fill.
    applyStimulus(1'b0, 14'd0, 1'b1, 14'd600, 8'h77, 1'b0, 8'h00);
    idle(3);
    fillColor = 8'hE0;
    startWr   = fillWrites;
    applyStimulus(1'b0, 14'd0, 1'b0, 14'd0, 8'h00, 1'b1, 8'hE0);
    for (int i = 0; i < 2000; i++) begin
      idle(1);
      if (fillWrites - startWr >= 500) break;
    end
    cut = fillWrites - startWr;
    checkOutput("cut_point", cut, 500);
    reset = 1'b1;
    #1;
    checkOutput("rst2_mem_we", mem_we, 0);
    checkOutput("rst2_mem_addr", mem_addr, 0);
    checkOutput("rst2_mem_wdata", mem_wdata, 0);
    checkOutput("rst2_clear_busy", clear_busy, 0);
    checkOutput("rst2_vid_valid", vid_valid, 0);
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    #1;
    checkOutput("rst2_cpu_ready", cpu_ready, 1);
    spots[0] = 14'd600;
    spots[1] = 14'd0;
    spots[2] = 14'd499;
    spots[3] = 14'd500;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, spots[i], 1'b0, 14'd0, 8'h00, 1'b0, 8'h00);
    idle(4);
    checkOutput("rst2_exp_600", exp_mem[600], 8'h77);
    checkOutput("rst2_exp_500", exp_mem[500], 8'h1C);

    // A fresh fill is accepted after the aborted one.
    fillColor = 8'h33;
    startWr   = fillWrites;
    startBad  = fillBad;
    applyStimulus(1'b0, 14'd0, 1'b0, 14'd0, 8'h00, 1'b1, 8'h33);
    idle(1);
    @(negedge pclk);
    checkOutput("restart_busy", clear_busy, 1);
    waitFillDone(busyCnt);
    idle(2);
    checkOutput("restart_count", fillWrites - startWr, 16000);
    checkOutput("restart_bad", fillBad - startBad, 0);
    checkOutput("vid_left", vq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
